// File: rtl/router_pkg.sv
// Shared constants, state encoding and header packing for the router packet transmitter.
package router_pkg;

    localparam int unsigned MAX_LEN     = 63;
    localparam int unsigned LEN_W       = 6;
    localparam int unsigned HDR_ADDR_W  = 2;
    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned HDR_LEN_LSB = 2;
    localparam int unsigned BUF_DEPTH   = MAX_LEN + 1;

    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StLoad = 3'd1;
    localparam state_t StHdr  = 3'd2;
    localparam state_t StPld  = 3'd3;
    localparam state_t StPar  = 3'd4;

    // Header byte: length in [7:2], destination port in [1:0].
    function automatic logic [7:0] make_hdr(input logic [LEN_W-1:0]      hdr_len,
                                            input logic [HDR_ADDR_W-1:0] hdr_addr);
        logic [7:0] hdr;
        hdr                           = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]  = hdr_len;
        hdr[HDR_ADDR_W-1:0]           = hdr_addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8, single write port, read port with a registered address so the
// controller can steer the next byte one cycle ahead.
module router_tx_buf
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0]       mem [BUF_DEPTH];
    logic [LEN_W-1:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= '0;
        end else begin
            rd_addr_q <= rd_addr;
        end
    end

    assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the router input port: buffers a payload, then sends
// header, payload and parity under the router's busy back-pressure.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [HDR_ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]      len,
    input  logic [7:0]            pl_data,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic                  abort,
    input  logic                  busy,
    output logic [7:0]            data_out,
    output logic                  pkt_valid,
    output logic                  tx_ready,
    output logic                  done,
    output logic                  err
);

    state_t                state_q,     state_d;
    logic [HDR_ADDR_W-1:0] addr_q,      addr_d;
    logic [LEN_W-1:0]      len_q,       len_d;
    logic [LEN_W-1:0]      count_q,     count_d;
    logic [7:0]            parity_q,    parity_d;
    logic [7:0]            data_out_q,  data_out_d;
    logic                  pkt_valid_q, pkt_valid_d;
    logic                  pl_ready_q,  pl_ready_d;
    logic                  tx_ready_q,  tx_ready_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;

    logic       buf_we;
    logic [7:0] buf_rd_data;

    // count_d doubles as the buffer read pointer, so the byte after the one on
    // data_out is already at the buffer output when it is accepted.
    router_tx_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (buf_we),
        .wr_addr (count_q),
        .wr_data (pl_data),
        .rd_addr (count_d),
        .rd_data (buf_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        count_d     = count_q;
        parity_d    = parity_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        buf_we      = 1'b0;

        if (abort) begin
            state_d     = StIdle;
            count_d     = '0;
            parity_d    = '0;
            data_out_d  = '0;
            pkt_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (addr == ADDR_INVALID || len == '0) begin
                            err_d = 1'b1;
                        end else begin
                            addr_d   = addr;
                            len_d    = len;
                            count_d  = '0;
                            parity_d = '0;
                            state_d  = StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (pl_valid) begin
                        buf_we   = 1'b1;
                        parity_d = parity_q ^ pl_data;
                        // Compare before incrementing so len=63 never wraps the counter.
                        if (count_q == len_q - 6'd1) begin
                            count_d     = '0;
                            data_out_d  = make_hdr(len_q, addr_q);
                            pkt_valid_d = 1'b1;
                            state_d     = StHdr;
                        end else begin
                            count_d = count_q + 6'd1;
                        end
                    end
                end
                StHdr: begin
                    if (!busy) begin
                        parity_d   = parity_q ^ data_out_q;
                        data_out_d = buf_rd_data;
                        count_d    = 6'd1;
                        state_d    = StPld;
                    end
                end
                StPld: begin
                    if (!busy) begin
                        if (count_q == len_q) begin
                            data_out_d  = parity_q;
                            pkt_valid_d = 1'b0;
                            state_d     = StPar;
                        end else begin
                            data_out_d = buf_rd_data;
                            count_d    = count_q + 6'd1;
                        end
                    end
                end
                StPar: begin
                    if (!busy) begin
                        data_out_d = '0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    data_out_d  = '0;
                    pkt_valid_d = 1'b0;
                end
            endcase
        end

        tx_ready_d = (state_d == StIdle);
        pl_ready_d = (state_d == StLoad);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            parity_q    <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            tx_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            parity_q    <= parity_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            pl_ready_q  <= pl_ready_d;
            tx_ready_q  <= tx_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign pkt_valid = pkt_valid_q;
    assign pl_ready  = pl_ready_q;
    assign tx_ready  = tx_ready_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: hand-computed byte streams checked with immediate asserts.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       abort;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_ready;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr      (addr),
        .len       (len),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .abort     (abort),
        .busy      (busy),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .err       (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic pv);
        chk({tag, ".data"}, 32'(data_out), 32'(d));
        chk({tag, ".pv"}, 32'(pkt_valid), 32'(pv));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_out(tag, 8'h00, 1'b0);
        chk({tag, ".pl_ready"}, 32'(pl_ready), 32'd0);
        chk({tag, ".tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
    endtask

    task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
        start = 1'b1;
        addr  = a;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        pl_valid = 1'b1;
        pl_data  = b;
        step();
        pl_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        addr     = 2'd0;
        len      = 6'd0;
        pl_data  = 8'h00;
        pl_valid = 1'b0;
        abort    = 1'b0;
        busy     = 1'b0;

        // Reset values
        #1 rst = 1'b0;
        #2;
        chk_idle_outputs("reset");
        step();
        rst = 1'b1;
        step();

        // Basic packet: addr=1 len=3, header 0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D
        start_pkt(2'd1, 6'd3);
        chk("t1.pl_ready", 32'(pl_ready), 32'd1);
        chk("t1.tx_ready", 32'(tx_ready), 32'd0);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk_out("t1.hdr", 8'h0D, 1'b1);
        chk("t1.pl_ready_drop", 32'(pl_ready), 32'd0);
        step(); chk_out("t1.p0", 8'h11, 1'b1);
        step(); chk_out("t1.p1", 8'h22, 1'b1);
        step(); chk_out("t1.p2", 8'h33, 1'b1);
        step(); chk_out("t1.par", 8'h0D, 1'b0);
        chk("t1.done_early", 32'(done), 32'd0);
        step();
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.tx_ready_back", 32'(tx_ready), 32'd1);
        chk_out("t1.after", 8'h00, 1'b0);

        // Back-to-back start on the done cycle, busy for 2 cycles on the second payload byte
        start_pkt(2'd1, 6'd3);
        chk("t2.accepted", 32'(pl_ready), 32'd1);
        chk("t2.done_low", 32'(done), 32'd0);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk_out("t2.hdr", 8'h0D, 1'b1);
        step(); chk_out("t2.p0", 8'h11, 1'b1);
        step(); chk_out("t2.p1a", 8'h22, 1'b1);
        busy = 1'b1;
        step(); chk_out("t2.p1b", 8'h22, 1'b1);
        step(); chk_out("t2.p1c", 8'h22, 1'b1);
        busy = 1'b0;
        step(); chk_out("t2.p2", 8'h33, 1'b1);
        step(); chk_out("t2.par", 8'h0D, 1'b0);
        step(); chk("t2.done", 32'(done), 32'd1);
        step(); chk("t2.done_pulse", 32'(done), 32'd0);

        // Illegal start fields
        start_pkt(2'd3, 6'd5);
        chk("t3.err_addr", 32'(err), 32'd1);
        chk("t3.tx_ready_a", 32'(tx_ready), 32'd1);
        chk("t3.pv_a", 32'(pkt_valid), 32'd0);
        chk("t3.pl_ready_a", 32'(pl_ready), 32'd0);
        step();
        chk("t3.err_pulse", 32'(err), 32'd0);
        start_pkt(2'd0, 6'd0);
        chk("t3.err_len", 32'(err), 32'd1);
        chk("t3.tx_ready_l", 32'(tx_ready), 32'd1);
        chk("t3.pv_l", 32'(pkt_valid), 32'd0);
        step();
        chk("t3.err_clear", 32'(err), 32'd0);
        chk("t3.pv_still", 32'(pkt_valid), 32'd0);

        // Max length, pl_valid every other cycle: header 0xFE, parity 0xFE^0x3F = 0xC1
        start_pkt(2'd2, 6'd63);
        for (int i = 0; i < 63; i++) begin
            push(8'(i));
            if (i < 62) begin
                chk("t4.pl_ready", 32'(pl_ready), 32'd1);
                step();
            end
        end
        chk_out("t4.hdr", 8'hFE, 1'b1);
        for (int i = 0; i < 63; i++) begin
            step();
            chk_out("t4.pld", 8'(i), 1'b1);
        end
        step(); chk_out("t4.par", 8'hC1, 1'b0);
        step(); chk("t4.done", 32'(done), 32'd1);

        // Abort in PLD after two payload bytes
        step();
        start_pkt(2'd0, 6'd4);
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        push(8'hD4);
        chk_out("t5.hdr", 8'h10, 1'b1);
        step(); chk_out("t5.p0", 8'hA1, 1'b1);
        step(); chk_out("t5.p1", 8'hB2, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_out("t5.aborted", 8'h00, 1'b0);
        chk("t5.no_done", 32'(done), 32'd0);
        chk("t5.tx_ready", 32'(tx_ready), 32'd1);
        step();
        chk("t5.no_done_late", 32'(done), 32'd0);
        // Clean packet afterwards: header 0x0A, parity 0x0A^0x5A^0xA5 = 0xF5
        start_pkt(2'd2, 6'd2);
        push(8'h5A);
        push(8'hA5);
        chk_out("t5.c_hdr", 8'h0A, 1'b1);
        step(); chk_out("t5.c_p0", 8'h5A, 1'b1);
        step(); chk_out("t5.c_p1", 8'hA5, 1'b1);
        step(); chk_out("t5.c_par", 8'hF5, 1'b0);
        step(); chk("t5.c_done", 32'(done), 32'd1);

        // Reset mid-HDR while busy
        start_pkt(2'd1, 6'd2);
        push(8'h01);
        push(8'h02);
        busy = 1'b1;
        chk_out("t6.hdr", 8'h09, 1'b1);
        step(); chk_out("t6.hdr_held", 8'h09, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_idle_outputs("t6.rst");
        step();
        rst  = 1'b1;
        busy = 1'b0;
        step();
        chk_idle_outputs("t6.post");
        // Recovery: addr=0 len=1, header 0x04, parity 0x04^0x77 = 0x73
        start_pkt(2'd0, 6'd1);
        push(8'h77);
        chk_out("t6.r_hdr", 8'h04, 1'b1);
        step(); chk_out("t6.r_p0", 8'h77, 1'b1);
        step(); chk_out("t6.r_par", 8'h73, 1'b0);
        step(); chk("t6.r_done", 32'(done), 32'd1);
        step(); chk("t6.r_done_pulse", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
